// File: rtl/board_pkg.sv
// Shared constants and types for the game-board row transmitter.
// A row packs COLS cells of CW bits; column c occupies bits [CW*c +: CW].
package board_pkg;

  localparam int ROWS = 20;
  localparam int COLS = 10;
  localparam int CW   = 3;
  localparam int IDXW = 5;

  typedef logic [CW-1:0] color_t;

  typedef enum logic [CW-1:0] {
    EMPTY  = 3'd0,
    CYAN   = 3'd1,
    BLUE   = 3'd2,
    ORANGE = 3'd3,
    YELLOW = 3'd4,
    GREEN  = 3'd5,
    PURPLE = 3'd6,
    RED    = 3'd7
  } piece_color_e;

  typedef color_t [COLS-1:0] row_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PICK = 2'd1,
    SEND = 2'd2
  } state_t;

  // Overlay one cell onto a row image.
  function automatic row_t merge_cell(input row_t r, input logic [3:0] col, input color_t c);
    row_t m;
    m      = r;
    m[col] = c;
    return m;
  endfunction

endpackage

// File: rtl/board_row_tx_if.sv
// Row bus between the transmitter (master) and the Graphics module (slave).
// Handshake: master raises bus_valid with bus_data/bus_index and holds all three
// stable until an edge samples bus_valid && bus_ack; bus_ack with bus_valid low is ignored.
interface board_row_tx_if;

  board_pkg::row_t                   bus_data;
  logic [board_pkg::IDXW-1:0]        bus_index;
  logic                              bus_valid;
  logic                              bus_ack;

  modport master (
    output bus_data,
    output bus_index,
    output bus_valid,
    input  bus_ack
  );

  modport slave (
    input  bus_data,
    input  bus_index,
    input  bus_valid,
    output bus_ack
  );

endinterface

// File: rtl/lowest_dirty_enc.sv
// Combinational priority encoder: index of the lowest set bit of a dirty vector.
module lowest_dirty_enc #(
  parameter int N  = 20,
  parameter int IW = 5
) (
  input  logic [N-1:0]  dirty,
  output logic          found,
  output logic [IW-1:0] idx
);

  // Scan downward so the lowest set bit is the last one to win.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (dirty[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/board_row_tx.sv
// Shadow playfield written by the CPU; after each frame_sync every dirty row is
// streamed to Graphics over the row bus, lowest row index first.
module board_row_tx
  import board_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             cell_we,
  input  logic [IDXW-1:0]  cell_row,
  input  logic [3:0]       cell_col,
  input  color_t           cell_color,
  input  logic             clear_req,
  input  logic             frame_sync,
  board_row_tx_if.master   bus,
  output logic             busy,
  output state_t           state_dbg
);

  localparam logic [IDXW:0] ROW_LIM = (IDXW + 1)'(ROWS);
  localparam logic [3:0]    COL_LIM = 4'(COLS);

  row_t            board [ROWS];
  logic [ROWS-1:0] dirty;
  logic [ROWS-1:0] dirty_nxt;
  state_t          state;
  state_t          state_nxt;
  logic            hold;
  logic            found;
  logic [IDXW-1:0] pick_idx;
  logic            wr_ok;
  logic            hit_cur;
  logic            load;
  logic            ack_take;
  row_t            snap;

  assign wr_ok = cell_we && ({1'b0, cell_row} < ROW_LIM) && (cell_col < COL_LIM);

  // A write to the in-flight row (or a clear) must keep that row dirty past its ack.
  assign hit_cur = clear_req || (wr_ok && (cell_row == bus.bus_index));

  lowest_dirty_enc #(
    .N  (ROWS),
    .IW (IDXW)
  ) u_enc (
    .dirty (dirty),
    .found (found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    ack_take  = 1'b0;
    case (state)
      IDLE: if (frame_sync) state_nxt = PICK;
      PICK: begin
        if (found) begin
          load      = 1'b1;
          state_nxt = SEND;
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (bus.bus_ack) begin
          ack_take  = 1'b1;
          state_nxt = PICK;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Snapshot of the picked row as it will look after this edge's update.
  always_comb begin
    snap = board[pick_idx];
    if (clear_req) begin
      snap = '0;
    end else if (wr_ok && (cell_row == pick_idx)) begin
      snap = merge_cell(board[pick_idx], cell_col, cell_color);
    end
  end

  always_comb begin
    dirty_nxt = dirty;
    if (ack_take && !hold && !hit_cur) dirty_nxt[bus.bus_index] = 1'b0;
    if (wr_ok) dirty_nxt[cell_row] = 1'b1;
    if (clear_req) dirty_nxt = '1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      dirty         <= '1;
      hold          <= 1'b0;
      bus.bus_valid <= 1'b0;
      bus.bus_data  <= '0;
      bus.bus_index <= '0;
      for (int r = 0; r < ROWS; r++) board[r] <= '0;
    end else begin
      state <= state_nxt;
      dirty <= dirty_nxt;
      if (clear_req) begin
        for (int r = 0; r < ROWS; r++) board[r] <= '0;
      end else if (wr_ok) begin
        board[cell_row][cell_col] <= cell_color;
      end
      if (load) begin
        hold          <= 1'b0;
        bus.bus_valid <= 1'b1;
        bus.bus_data  <= snap;
        bus.bus_index <= pick_idx;
      end else begin
        if (state == SEND && hit_cur) hold <= 1'b1;
        if (ack_take) bus.bus_valid <= 1'b0;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_board_row_tx.sv
// Directed bench for board_row_tx: full-board passes, single dirty rows,
// backpressure, mid-SEND rewrites, out-of-range writes, clear and async reset.
module tb_board_row_tx;
  import board_pkg::*;

  logic            clk;
  logic            rst;
  logic            cell_we;
  logic [IDXW-1:0] cell_row;
  logic [3:0]      cell_col;
  color_t          cell_color;
  logic            clear_req;
  logic            frame_sync;
  logic            busy;
  state_t          state_dbg;

  board_row_tx_if rb ();

  board_row_tx dut (
    .clk        (clk),
    .rst        (rst),
    .cell_we    (cell_we),
    .cell_row   (cell_row),
    .cell_col   (cell_col),
    .cell_color (cell_color),
    .clear_req  (clear_req),
    .frame_sync (frame_sync),
    .bus        (rb.master),
    .busy       (busy),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [34:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic write_cell(input int row, input int col, input int color);
    cell_we    = 1'b1;
    cell_row   = IDXW'(row);
    cell_col   = 4'(col);
    cell_color = CW'(color);
    tick();
    cell_we    = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_sync = 1'b1;
    tick();
    frame_sync = 1'b0;
  endtask

  // scoreboard: run until busy drops, comparing each payload against exp_q
  task automatic collect(input string tag, input int exp_n);
    int n;
    int t;
    int last_v;
    n      = 0;
    t      = 0;
    last_v = 0;
    while (t < 200) begin
      tick();
      t++;
      chk({tag, "_valid_idle"}, 64'(rb.bus_valid && !busy), 64'd0);
      if (rb.bus_valid) begin
        n++;
        last_v = t;
        if (exp_q.size() == 0) chk({tag, "_extra_xfer"}, 64'({rb.bus_index, rb.bus_data}), 64'h7ffffffff);
        else chk({tag, "_xfer"}, 64'({rb.bus_index, rb.bus_data}), 64'(exp_q.pop_front()));
      end
      if (!busy) break;
    end
    if (busy) chk({tag, "_timeout"}, 64'd1, 64'd0);
    chk({tag, "_count"}, 64'(n), 64'(exp_n));
    chk({tag, "_exp_left"}, 64'(exp_q.size()), 64'd0);
    if (n > 0) chk({tag, "_busy_drop"}, 64'(t), 64'(last_v + 2));
    exp_q.delete();
  endtask

  task automatic expect_all_zero();
    for (int r = 0; r < ROWS; r++) exp_q.push_back({IDXW'(r), 30'h0});
  endtask

  initial begin
    rst        = 1'b0;
    cell_we    = 1'b0;
    cell_row   = '0;
    cell_col   = '0;
    cell_color = '0;
    clear_req  = 1'b0;
    frame_sync = 1'b0;
    rb.bus_ack = 1'b1;
    tick();
    tick();
    chk("rst_valid", 64'(rb.bus_valid), 64'd0);
    chk("rst_data", 64'(rb.bus_data), 64'd0);
    chk("rst_index", 64'(rb.bus_index), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(IDLE));
    rst = 1'b1;
    tick();

    // 1: first pass paints the empty board
    pulse_frame();
    chk("t1_lat_valid", 64'(rb.bus_valid), 64'd0);
    chk("t1_lat_busy", 64'(busy), 64'd1);
    expect_all_zero();
    collect("t1", 20);

    // 2: single dirty row
    tick();
    pulse_frame();
    collect("t2_idle", 0);
    write_cell(3, 4, 5);
    pulse_frame();
    exp_q.push_back({5'd3, 30'h0000_5000});
    collect("t2", 1);
    chk("t2_busy", 64'(busy), 64'd0);

    // 3: backpressure holds the payload
    rb.bus_ack = 1'b0;
    write_cell(10, 9, 7);
    pulse_frame();
    tick();
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_valid", 64'(rb.bus_valid), 64'd1);
      chk("t3_hold_index", 64'(rb.bus_index), 64'd10);
      chk("t3_hold_data", 64'(rb.bus_data), 64'h3800_0000);
      if (i < 9) tick();
    end
    rb.bus_ack = 1'b1;
    tick();
    chk("t3_ack_valid", 64'(rb.bus_valid), 64'd0);
    chk("t3_ack_busy", 64'(busy), 64'd1);
    tick();
    chk("t3_done_busy", 64'(busy), 64'd0);

    // 4: rewrite of the in-flight row
    rb.bus_ack = 1'b0;
    write_cell(7, 5, 3);
    write_cell(9, 1, 6);
    pulse_frame();
    tick();
    chk("t4_first", 64'({rb.bus_valid, rb.bus_index, rb.bus_data}), 64'({1'b1, 5'd7, 30'h0001_8000}));
    write_cell(7, 0, 2);
    chk("t4_inflight", 64'({rb.bus_valid, rb.bus_index, rb.bus_data}), 64'({1'b1, 5'd7, 30'h0001_8000}));
    exp_q.push_back({5'd7, 30'h0001_8002});
    exp_q.push_back({5'd9, 30'h0000_0030});
    rb.bus_ack = 1'b1;
    collect("t4", 2);

    // 5: out-of-range writes, then clear beats a same-cycle write
    write_cell(25, 0, 1);
    write_cell(2, 12, 1);
    pulse_frame();
    collect("t5_oor", 0);
    clear_req  = 1'b1;
    cell_we    = 1'b1;
    cell_row   = 5'd1;
    cell_col   = 4'd2;
    cell_color = 3'd4;
    tick();
    clear_req  = 1'b0;
    cell_we    = 1'b0;
    pulse_frame();
    expect_all_zero();
    collect("t5_clear", 20);

    // 6: async reset mid-SEND
    rb.bus_ack = 1'b0;
    write_cell(4, 4, 4);
    pulse_frame();
    tick();
    chk("t6_pre_valid", 64'(rb.bus_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_async_valid", 64'(rb.bus_valid), 64'd0);
    chk("t6_async_busy", 64'(busy), 64'd0);
    tick();
    rst = 1'b1;
    rb.bus_ack = 1'b1;
    tick();
    pulse_frame();
    expect_all_zero();
    collect("t6", 20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
